// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction memory request/response bus
interface pc_fetch_if;
  logic req;
  logic [31:0] addr;
  logic ack;
  logic [31:0] rdata;
  modport master (output req, addr, input ack, rdata);
  modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: program counter, instruction fetch/issue sequencing and interrupt/eret handling
module pc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] INT_VECTOR = 32'hBFC0_0380
) (
  input  logic clk,
  input  logic reset,
  input  logic [1:0] pcsrc,
  input  logic [1:0] pcbranchsrc,
  input  logic [31:0] rs_val,
  input  logic [25:0] imm,
  input  logic stall,
  input  logic irq,
  input  logic eret,
  pc_fetch_if.master imem,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] instr,
  output logic instr_valid,
  output logic [31:0] epc,
  output logic ie
);
  typedef enum logic {FETCH, ISSUE} state_t;
  state_t state, state_n;
  logic req, issue, take_int;
  logic [31:0] offset, target, next_pc;
  assign pcplus4 = pc + 32'd4;
  assign offset = {{14{imm[15]}}, imm[15:0], 2'b00};
  assign take_int = issue & irq & ie;
  assign imem.req = req;
  assign imem.addr = pc;
  // branch/jump target and the pc that would load at issue absent interrupt/eret
  always_comb begin
    target = pcbranchsrc == 2'b00 ? pcplus4 + offset :
             pcbranchsrc == 2'b01 ? rs_val & ~32'd3 :
             pcbranchsrc == 2'b10 ? {pcplus4[31:28], imm, 2'b00} : pcplus4;
    next_pc = pcsrc == 2'b00 ? RESET_VECTOR :
              pcsrc == 2'b01 ? INT_VECTOR :
              pcsrc == 2'b10 ? pcplus4 : target;
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= state_n;
  // next state and handshake outputs; acks seen while issuing are ignored
  always_comb begin
    state_n = state;
    req = 1'b0;
    instr_valid = 1'b0;
    issue = 1'b0;
    if (state == FETCH) begin
      req = 1'b1;
      if (imem.ack) state_n = ISSUE;
    end else begin
      instr_valid = 1'b1;
      if (!stall) begin
        issue = 1'b1;
        state_n = FETCH;
      end
    end
  end
  // instruction capture, pc update and exception state; interrupt beats eret, which beats pcsrc
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= RESET_VECTOR;
      instr <= '0;
      epc <= '0;
      ie <= 1'b0;
    end else begin
      if (req && imem.ack) instr <= imem.rdata;
      if (take_int) begin
        pc <= INT_VECTOR;
        ie <= 1'b0;
        if (!eret) epc <= next_pc;
      end else if (issue && eret) begin
        pc <= epc;
        ie <= 1'b1;
      end else if (issue) pc <= next_pc;
    end
endmodule
